// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM states, M-field bit positions, x0 index.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  // Bit positions inside the 3-bit M control group carried in ID/EX
  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

  // x0 is hard-wired zero, so a load targeting it can never create a dependency
  localparam logic [4:0] REG_X0 = 5'd0;

  // Load-use dependency between the load in ID/EX and the instruction in IF/ID
  function automatic logic load_use_hazard(input logic       mem_read,
                                           input logic [4:0] rd,
                                           input logic [4:0] rs1,
                                           input logic [4:0] rs2);
    return mem_read && (rd != REG_X0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones instead of wrapping.
// Latency: count reflects an inc one clock after it is sampled.
// Backpressure: none; inc is accepted every cycle.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Synchronous clear, then increment unless already pinned at the maximum
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls (STALL_CYCLES bubbles) and taken-branch flushes, with statistics.
// Latency: control outputs are combinational from state and current inputs; counters update one clock later.
// Backpressure: stalls the front end by dropping PCWrite/IFIDWrite; a taken branch always overrides a stall.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       IFID_RS1,
  input  logic [4:0]       IFID_RS2,
  input  logic [4:0]       IDEX_RD,
  input  logic [2:0]       IDEX_M,
  input  logic             Branch_Taken,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             EXMEM_Flush,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  // Remaining stall cycles after the one that detected the hazard
  localparam logic [1:0] REM_INIT = 2'(STALL_CYCLES - 1);

  state_t     state, state_nxt;
  logic [1:0] rem, rem_nxt;
  logic       hz;
  logic       stall_inc;
  logic       flush_inc;

  // Only MemRead matters here; Branch and MemWrite are resolved elsewhere in the pipe
  logic unused_m;
  assign unused_m = IDEX_M[M_BRANCH] ^ IDEX_M[M_MEMWRITE];

  assign hz = load_use_hazard(IDEX_M[M_MEMREAD], IDEX_RD, IFID_RS1, IFID_RS2);

  // Next state and all control outputs; branch beats stall, reset beats everything
  always_comb begin
    state_nxt   = state;
    rem_nxt     = rem;
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    EXMEM_Flush = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    case (state)
      RUN: begin
        if (hz) begin
          PCWrite     = 1'b0;
          IFIDWrite   = 1'b0;
          IDEX_Bubble = 1'b1;
          stall_inc   = 1'b1;
          if (STALL_CYCLES > 1) begin
            state_nxt = STALL;
            rem_nxt   = REM_INIT;
          end
        end
      end
      STALL: begin
        // hz is deliberately ignored here: the front end is frozen anyway
        PCWrite     = 1'b0;
        IFIDWrite   = 1'b0;
        IDEX_Bubble = 1'b1;
        stall_inc   = 1'b1;
        if (rem <= 2'd1) begin
          state_nxt = RUN;
          rem_nxt   = 2'd0;
        end else begin
          rem_nxt = rem - 2'd1;
        end
      end
      default: begin
        state_nxt = RUN;
        rem_nxt   = 2'd0;
      end
    endcase

    // A taken branch squashes the wrong-path work and aborts any stall in progress
    if (Branch_Taken) begin
      PCWrite     = 1'b1;
      IFIDWrite   = 1'b1;
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
      EXMEM_Flush = 1'b1;
      stall_inc   = 1'b0;
      flush_inc   = 1'b1;
      state_nxt   = RUN;
      rem_nxt     = 2'd0;
    end

    // Held in reset the pipe free-runs regardless of what the stage registers hold
    if (!reset_n) begin
      PCWrite     = 1'b1;
      IFIDWrite   = 1'b1;
      IFID_Flush  = 1'b0;
      IDEX_Bubble = 1'b0;
      EXMEM_Flush = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      state_nxt   = RUN;
      rem_nxt     = 2'd0;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= RUN;
      rem   <= 2'd0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (stall_inc),
    .count   (StallCount)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (flush_inc),
    .count   (FlushCount)
  );

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter STALL_CYCLES, default 1, load-use stall length in cycles; legal 1..3.
REQ-002 Parameter CNT_W, default 32, width of the statistics counters.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 IFID_RS1  input  5  rs1 field of the instruction in IF/ID.
REQ-006 IFID_RS2  input  5  rs2 field of the instruction in IF/ID.
REQ-007 IDEX_RD  input  5  rd held in ID/EX.
REQ-008 IDEX_M  input  3  M control held in ID/EX: [2]=Branch, [1]=MemRead, [0]=MemWrite.
REQ-009 Branch_Taken  input  1  branch resolved taken in EX/MEM this cycle.
REQ-010 PCWrite  output  1  PC update enable.
REQ-011 IFIDWrite  output  1  IF/ID load enable.
REQ-012 IFID_Flush  output  1  clear IF/ID to NOP.
REQ-013 IDEX_Bubble  output  1  force ID/EX WB, M and EX controls to zero.
REQ-014 EXMEM_Flush  output  1  force EX/MEM WB and M controls to zero.
REQ-015 StallCount  output  CNT_W  total bubble cycles inserted for load-use hazards.
REQ-016 FlushCount  output  CNT_W  total taken-branch flushes.

Function
REQ-017 FSM states: RUN, STALL. Counter rem[1:0] holds remaining stall cycles.
REQ-018 Hazard condition hz = IDEX_M[1] & (IDEX_RD != 0) & ((IDEX_RD == IFID_RS1) | (IDEX_RD == IFID_RS2)).
REQ-019 All five control outputs are combinational from state, rem and the current inputs; zero added latency.
REQ-020 RUN, no Branch_Taken, no hz: PCWrite=1, IFIDWrite=1, all flush/bubble outputs 0.
REQ-021 RUN with hz and no Branch_Taken: PCWrite=0, IFIDWrite=0, IDEX_Bubble=1, StallCount+1. If STALL_CYCLES>1, next state is STALL with rem=STALL_CYCLES-1; otherwise remain in RUN.
REQ-022 STALL: PCWrite=0, IFIDWrite=0, IDEX_Bubble=1, StallCount+1, rem-1. Return to RUN when rem reaches 1 at a clock edge. hz is ignored while in STALL.
REQ-023 Branch_Taken in any state: IFID_Flush=1, IDEX_Bubble=1, EXMEM_Flush=1, PCWrite=1, IFIDWrite=1, FlushCount+1; next state RUN with rem=0.
REQ-024 Branch_Taken and hz in the same cycle: the branch wins; no stall cycle is counted.
REQ-025 Branch_Taken during STALL aborts the stall that cycle; the abort cycle is not counted in StallCount.
REQ-026 Counters saturate at all-ones and do not wrap.
REQ-027 IDEX_RD=0 never produces a stall, even with MemRead=1.

Reset
REQ-028 With reset_n=0 at posedge clk: state=RUN, rem=0, StallCount=0, FlushCount=0.
REQ-029 While reset_n=0: PCWrite=1, IFIDWrite=1, IFID_Flush=0, IDEX_Bubble=0, EXMEM_Flush=0, independent of inputs.
REQ-030 Reset during STALL abandons the stall; the first cycle after reset is evaluated as RUN.

Structure
REQ-031 The shared pipeline package holds the state enum (RUN, STALL), the M-field bit index constants (M_BRANCH=2, M_MEMREAD=1, M_MEMWRITE=0) and the x0 register index constant.
REQ-032 A single sub-module sat_counter (parameter CNT_W; inputs clk, reset_n, inc; output count) is instantiated twice.

Verification
REQ-033 Load-use test: IDEX_M=3'b010, IDEX_RD=5, IFID_RS2=5, STALL_CYCLES=1 -> one cycle with PCWrite=0, IFIDWrite=0, IDEX_Bubble=1; StallCount=1; next cycle normal.
REQ-034 STALL_CYCLES=3 with the same hazard -> three consecutive bubble cycles; StallCount=3; back in RUN on the fourth cycle.
REQ-035 Branch_Taken=1 in the second STALL cycle (STALL_CYCLES=3) -> all three flush outputs 1, PCWrite=1; StallCount=1, FlushCount=1; RUN next cycle.
REQ-036 Simultaneous hz and Branch_Taken -> flush response only; StallCount unchanged, FlushCount+1.
REQ-037 IDEX_RD=0, IFID_RS1=0, IDEX_M=3'b010 -> no stall; and a store (IDEX_M=3'b001) with matching rd -> no stall.
REQ-038 CNT_W=4, 20 back-to-back hazards -> StallCount holds 4'hF; reset_n=0 for one edge -> both counters 0.
